// File: rtl/wimax_fec_pkg.sv
// Shared constants, state type and encoder tap function for the WiMAX FEC chain.
// Encoder state is {s1..s6} with s1 in the MSB, so {b, state} lines up with the octal generators.
package wimax_fec_pkg;

  localparam int N_IN  = 96;
  localparam int N_OUT = 2 * N_IN;

  localparam logic [6:0] G1 = 7'o171;
  localparam logic [6:0] G2 = 7'o133;

  typedef logic [5:0] cc_state_t;

  typedef enum logic {
    IDLE,
    ENCODE
  } enc_fsm_t;

  function automatic logic cc_out(
    input logic       b,
    input cc_state_t  s,
    input logic [6:0] poly
  );
    return ^(poly & {b, s});
  endfunction

endpackage

// File: rtl/cc_core.sv
// K=7 shift register with X/Y generation; load overrides shift.
// Ports: clk, reset, load/load_state (tail-biting init), shift, d (current bit), x, y.
module cc_core
  import wimax_fec_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  cc_state_t load_state,
  input  logic      shift,
  input  logic      d,
  output logic      x,
  output logic      y
);

  cc_state_t st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= '0;
    end else if (load) begin
      st <= load_state;
    end else if (shift) begin
      st <= {d, st[5:1]};
    end
  end

  assign x = cc_out(d, st, G1);
  assign y = cc_out(d, st, G2);

endmodule

// File: rtl/cc_tailbite_encoder.sv
// Rate-1/2 K=7 tail-biting encoder, double-banked serial input, addressed serial output.
// Ports: clk, reset, in_bit/in_valid/in_ready, out_bit/out_addr/out_valid/out_ready, block_done.
module cc_tailbite_encoder
  import wimax_fec_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              block_done
);

  localparam int IW = $clog2(N_IN);
  localparam logic [IW-1:0] LAST = IW'(N_IN - 1);

  logic [1:0][N_IN-1:0] bank;
  logic [1:0]           full;
  logic                 fill_sel;
  logic                 enc_sel;
  logic [IW-1:0]        load_ptr;
  logic [IW-1:0]        bit_idx;
  logic                 phase;
  enc_fsm_t             fsm;
  enc_fsm_t             fsm_n;

  logic      in_xfer;
  logic      last_in;
  logic      out_xfer;
  logic      last_out;
  logic      load;
  logic      src;
  logic      bypass;
  cc_state_t ld_state;
  logic      d;
  logic      x;
  logic      y;

  assign in_ready   = !reset && !full[fill_sel];
  assign in_xfer    = in_valid && in_ready;
  assign last_in    = in_xfer && (load_ptr == LAST);
  assign out_valid  = (fsm == ENCODE);
  assign out_xfer   = out_valid && out_ready;
  assign last_out   = out_xfer && phase && (bit_idx == LAST);
  assign block_done = last_out && !reset;
  assign out_addr   = ADDR_W'({bit_idx, phase});
  assign d          = bank[enc_sel][bit_idx];
  assign out_bit    = out_valid && (phase ? y : x);

  // A bank completing this cycle still has b[95] on in_bit only.
  assign bypass   = last_in && (fill_sel == src);
  assign ld_state = bypass ? {in_bit, bank[src][N_IN-2 -: 5]}
                           : bank[src][N_IN-1 -: 6];

  always_comb begin
    fsm_n = fsm;
    load  = 1'b0;
    src   = fill_sel;
    unique case (fsm)
      IDLE: begin
        if (last_in) begin
          fsm_n = ENCODE;
          load  = 1'b1;
        end
      end
      ENCODE: begin
        if (last_out) begin
          src = ~enc_sel;
          if (full[src] || (last_in && (fill_sel == src))) begin
            load = 1'b1;
          end else begin
            fsm_n = IDLE;
          end
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      bank[fill_sel][load_ptr] <= in_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full     <= '0;
      fill_sel <= 1'b0;
      enc_sel  <= 1'b0;
      load_ptr <= '0;
      bit_idx  <= '0;
      phase    <= 1'b0;
      fsm      <= IDLE;
    end else begin
      fsm <= fsm_n;
      if (in_xfer) begin
        load_ptr <= last_in ? '0 : load_ptr + 1'b1;
        if (last_in) begin
          fill_sel <= ~fill_sel;
        end
      end
      if (load) begin
        enc_sel <= src;
      end
      if (load || last_out) begin
        bit_idx <= '0;
        phase   <= 1'b0;
      end else if (out_xfer) begin
        phase <= ~phase;
        if (phase) begin
          bit_idx <= bit_idx + 1'b1;
        end
      end
      // Enc bank is full and fill bank is not, so these never collide.
      if (last_out) begin
        full[enc_sel] <= 1'b0;
      end
      if (last_in) begin
        full[fill_sel] <= 1'b1;
      end
    end
  end

  cc_core u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_state (ld_state),
    .shift      (out_xfer && phase),
    .d          (d),
    .x          (x),
    .y          (y)
  );

endmodule
